// File: rtl/pos_sweep_pkg.sv
// pos_sweep_pkg: shared types and constants for the POS minterm sweeper.
//   state_t       - sweep controller states (IDLE, SCAN, DRAIN)
//   *_VARS/*_CLAUSES limits - legal parameter ranges
//   POS_DEF/NEG_DEF - default masks for F = (A+B)(C+D)E with 5 vars, 3 clauses
//   sweep_size()  - number of input vectors visited for a given width
//   params_legal() - range check helper for parameter sets
package pos_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int MIN_VARS    = 2;
  localparam int MAX_VARS    = 16;
  localparam int MIN_CLAUSES = 1;
  localparam int MAX_CLAUSES = 16;

  // Clause 0 sits in the low 5 bits: clause0 = A+B, clause1 = C+D, clause2 = E.
  localparam logic [14:0] POS_DEF = {5'b00001, 5'b00110, 5'b11000};
  localparam logic [14:0] NEG_DEF = 15'b0;

  function automatic int sweep_size(input int n_vars);
    return 1 << n_vars;
  endfunction

  function automatic bit params_legal(input int n_vars, input int n_clauses);
    return (n_vars >= MIN_VARS) && (n_vars <= MAX_VARS) &&
           (n_clauses >= MIN_CLAUSES) && (n_clauses <= MAX_CLAUSES);
  endfunction

endpackage

// File: rtl/pos_clause_eval.sv
// pos_clause_eval: combinational product-of-sums evaluator.
//   vec      - input vector, bit N_VARS-1 = A (MSB)
//   pos_mask - clause k at [k*N_VARS +: N_VARS], set bit = uncomplemented literal
//   neg_mask - same layout, set bit = complemented literal
//   f        - AND over all clauses of (OR of selected literals)
// A clause with no literals evaluates 0, which forces f to 0.
module pos_clause_eval
  import pos_sweep_pkg::*;
#(
  parameter int N_VARS    = 5,
  parameter int N_CLAUSES = 3
) (
  input  logic [N_VARS-1:0]           vec,
  input  logic [N_CLAUSES*N_VARS-1:0] pos_mask,
  input  logic [N_CLAUSES*N_VARS-1:0] neg_mask,
  output logic                        f
);

  always_comb begin
    f = 1'b1;
    for (int k = 0; k < N_CLAUSES; k++) begin
      f = f & ((|(vec & pos_mask[k*N_VARS +: N_VARS])) |
               (|(~vec & neg_mask[k*N_VARS +: N_VARS])));
    end
  end

endmodule

// File: rtl/pos_minterm_sweep.sv
// pos_minterm_sweep: run-time programmable POS function with a minterm sweeper.
//   clk, rst_n        - clock, synchronous active-low reset
//   start             - begin a sweep (only honoured in IDLE)
//   pos_mask/neg_mask - clause literal masks, latched on an accepted start
//   busy, done        - sweep in progress / one-cycle end-of-sweep pulse
//   m_valid/m_ready/m_index - minterm output stream
//   count             - minterms found in the current or last sweep
//   eval_in/eval_out  - combinational spot evaluation on the live masks
//   state             - controller state, for observation
//
// Output handshake: a beat transfers on a rising clk edge where m_valid and
// m_ready are both 1. Once m_valid is raised, m_index stays stable until the
// beat transfers; m_valid never drops without a transfer (except on reset).
module pos_minterm_sweep
  import pos_sweep_pkg::*;
#(
  parameter int N_VARS    = 5,
  parameter int N_CLAUSES = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [N_CLAUSES*N_VARS-1:0] pos_mask,
  input  logic [N_CLAUSES*N_VARS-1:0] neg_mask,
  output logic                        busy,
  output logic                        done,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [N_VARS-1:0]           m_index,
  output logic [N_VARS:0]             count,
  input  logic [N_VARS-1:0]           eval_in,
  output logic                        eval_out,
  output state_t                      state
);

  localparam logic [N_VARS:0] IDX_LAST = {1'b0, {N_VARS{1'b1}}};

  state_t                      state_n;
  logic [N_VARS:0]             idx, idx_n;
  logic [N_CLAUSES*N_VARS-1:0] pos_q, pos_n;
  logic [N_CLAUSES*N_VARS-1:0] neg_q, neg_n;
  logic                        m_valid_n;
  logic [N_VARS-1:0]           m_index_n;
  logic [N_VARS:0]             count_n;
  logic                        done_n;
  logic                        f_scan;
  logic                        advance;

  // Sweep evaluator works on the snapshot taken at start.
  pos_clause_eval #(
    .N_VARS   (N_VARS),
    .N_CLAUSES(N_CLAUSES)
  ) u_scan_eval (
    .vec     (idx[N_VARS-1:0]),
    .pos_mask(pos_q),
    .neg_mask(neg_q),
    .f       (f_scan)
  );

  // Spot evaluator follows the live mask inputs.
  pos_clause_eval #(
    .N_VARS   (N_VARS),
    .N_CLAUSES(N_CLAUSES)
  ) u_spot_eval (
    .vec     (eval_in),
    .pos_mask(pos_mask),
    .neg_mask(neg_mask),
    .f       (eval_out)
  );

  // The output register can take a new value when empty or being drained.
  assign advance = !m_valid || m_ready;
  assign busy    = (state != IDLE);

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    pos_n     = pos_q;
    neg_n     = neg_q;
    m_valid_n = m_valid;
    m_index_n = m_index;
    count_n   = count;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pos_n   = pos_mask;
          neg_n   = neg_mask;
          idx_n   = '0;
          count_n = '0;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (advance) begin
          if (f_scan) begin
            m_index_n = idx[N_VARS-1:0];
            m_valid_n = 1'b1;
            count_n   = count + 1'b1;
          end else begin
            m_valid_n = 1'b0;
          end
          idx_n = idx + 1'b1;
          if (idx == IDX_LAST) begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (advance) begin
          m_valid_n = 1'b0;
          done_n    = 1'b1;
          state_n   = IDLE;
        end
      end
      default: begin
        state_n   = IDLE;
        m_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      m_valid <= 1'b0;
      m_index <= '0;
      count   <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      pos_q   <= pos_n;
      neg_q   <= neg_n;
      m_valid <= m_valid_n;
      m_index <= m_index_n;
      count   <= count_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_pos_minterm_sweep.sv
// tb_pos_minterm_sweep: scoreboard bench for pos_minterm_sweep (5 vars, 3 clauses).
module tb_pos_minterm_sweep;
  import pos_sweep_pkg::*;

  localparam int NV = 5;
  localparam int NC = 3;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [NC*NV-1:0] pos_mask;
  logic [NC*NV-1:0] neg_mask;
  logic            busy;
  logic            done;
  logic            m_valid;
  logic            m_ready;
  logic [NV-1:0]   m_index;
  logic [NV:0]     count;
  logic [NV-1:0]   eval_in;
  logic            eval_out;
  state_t          state;

  logic [NV-1:0] exp_q[$];
  int n_checks;
  int n_errors;
  int done_cnt;
  int beats_seen;
  bit rand_mode;

  pos_minterm_sweep #(
    .N_VARS   (NV),
    .N_CLAUSES(NC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .pos_mask(pos_mask),
    .neg_mask(neg_mask),
    .busy    (busy),
    .done    (done),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_index (m_index),
    .count   (count),
    .eval_in (eval_in),
    .eval_out(eval_out),
    .state   (state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference F: walk every literal of every clause individually.
  function automatic bit f_model(input logic [NV-1:0] v, input logic [NC*NV-1:0] p,
                                 input logic [NC*NV-1:0] n);
    bit f;
    bit c;
    f = 1'b1;
    for (int k = 0; k < NC; k++) begin
      c = 1'b0;
      for (int b = 0; b < NV; b++) begin
        if (p[k*NV+b] && v[b])  c = 1'b1;
        if (n[k*NV+b] && !v[b]) c = 1'b1;
      end
      f = f && c;
    end
    return f;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("m_index", 32'(m_index), 32'(exp_q.pop_front()));
      beats_seen++;
    end
    if (rst_n && done) done_cnt++;
  end

  // Random backpressure, applied late in the cycle so the main thread owns #1.
  always @(posedge clk) begin
    #3;
    if (rand_mode) m_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input logic [NC*NV-1:0] p, input logic [NC*NV-1:0] n,
                            output int cnt);
    cnt = 0;
    for (int v = 0; v < (1 << NV); v++) begin
      if (f_model(NV'(v), p, n)) begin
        exp_q.push_back(NV'(v));
        cnt++;
      end
    end
  endtask

  task automatic run_sweep(input string tag, input logic [NC*NV-1:0] p,
                           input logic [NC*NV-1:0] n, input bit rnd, input bit poke,
                           output int lat);
    int exp_cnt;
    pos_mask = p;
    neg_mask = n;
    push_model(p, n, exp_cnt);
    done_cnt   = 0;
    beats_seen = 0;
    m_ready    = 1'b1;
    rand_mode  = rnd;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    while (!done && lat < 2000) begin
      tick();
      lat++;
      if (poke && lat == 10) begin
        start    = 1'b1;
        pos_mask = '0;
      end
      if (poke && lat == 11) begin
        start    = 1'b0;
        pos_mask = p;
      end
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_count"}, 32'(count), 32'(exp_cnt));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    rand_mode = 1'b0;
    m_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_count_hold"}, 32'(count), 32'(exp_cnt));
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "_beats"}, 32'(beats_seen), 32'(exp_cnt));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_state_idle"}, 32'(state), 32'(IDLE));
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int wait_cnt;
    logic [NV-1:0] def_list[9] = '{5'd11, 5'd13, 5'd15, 5'd19, 5'd21,
                                   5'd23, 5'd27, 5'd29, 5'd31};
    logic [NC*NV-1:0] rp, rn;
    logic [NV-1:0] rv;

    n_checks = 0; n_errors = 0; done_cnt = 0; beats_seen = 0; rand_mode = 1'b0;
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b1; eval_in = '0;
    pos_mask = POS_DEF; neg_mask = NEG_DEF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_index", 32'(m_index), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst_n = 1'b1;
    tick();

    // Spot evaluation on the default function.
    eval_in = 5'b01011; #1;
    check("eval_01011", 32'(eval_out), 32'd1);
    eval_in = 5'b01010; #1;
    check("eval_01010", 32'(eval_out), 32'd0);
    for (int i = 0; i < 6; i++) begin
      rp = 15'($urandom) & 15'($urandom);
      rn = 15'($urandom) & 15'($urandom);
      rv = 5'($urandom);
      pos_mask = rp; neg_mask = rn; eval_in = rv; #1;
      check("eval_rand", 32'(eval_out), 32'(f_model(rv, rp, rn)));
    end

    // Default function, full throughput; confirm model agrees with the known list.
    push_model(POS_DEF, NEG_DEF, lat);
    for (int i = 0; i < 9; i++) check("model_default", 32'(exp_q[i]), 32'(def_list[i]));
    exp_q.delete();
    run_sweep("default", POS_DEF, NEG_DEF, 1'b0, 1'b0, lat);

    // Stall on the first beat.
    pos_mask = POS_DEF; neg_mask = NEG_DEF;
    for (int i = 0; i < 9; i++) exp_q.push_back(def_list[i]);
    done_cnt = 0; beats_seen = 0;
    m_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    wait_cnt = 0;
    while (!m_valid && wait_cnt < 100) begin tick(); wait_cnt++; end
    check("stall_valid_seen", 32'(m_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_index", 32'(m_index), 32'd11);
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_count", 32'(count), 32'd1);
      tick();
    end
    m_ready = 1'b1;
    wait_cnt = 0;
    while (!done && wait_cnt < 200) begin tick(); wait_cnt++; end
    check("stall_done_seen", 32'(done), 32'd1);
    check("stall_count_final", 32'(count), 32'd9);
    tick();
    check("stall_done_once", 32'(done_cnt), 32'd1);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Tautology in every clause: every vector is a minterm, count needs the extra bit.
    run_sweep("taut", {3{5'b10000}}, {3{5'b10000}}, 1'b0, 1'b0, lat);
    check("taut_count_msb", 32'(count), 32'd32);

    // Empty clause 2: no beats at all; done 34 edges after the start edge sequence.
    run_sweep("empty", POS_DEF & 15'h03FF, 15'h0000, 1'b0, 1'b0, lat);
    check("empty_done_latency", 32'(lat), 32'd34);

    // Start pulse and mask change mid-sweep must not disturb the sweep.
    run_sweep("poke", POS_DEF, NEG_DEF, 1'b0, 1'b1, lat);

    // Random functions with random backpressure.
    for (int i = 0; i < 3; i++) begin
      rp = 15'($urandom) | 15'($urandom);
      rn = 15'($urandom) & 15'($urandom);
      run_sweep("rand", rp, rn, 1'b1, 1'b0, lat);
    end

    // Reset mid-sweep after the third beat.
    pos_mask = POS_DEF; neg_mask = NEG_DEF;
    for (int i = 0; i < 9; i++) exp_q.push_back(def_list[i]);
    done_cnt = 0; beats_seen = 0; m_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_cnt = 0;
    while (beats_seen < 3 && wait_cnt < 100) begin tick(); wait_cnt++; end
    check("rstmid_beats", 32'(beats_seen), 32'd3);
    rst_n = 1'b0;
    tick();
    check("rstmid_m_valid", 32'(m_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_count", 32'(count), 32'd0);
    check("rstmid_state", 32'(state), 32'(IDLE));
    rst_n = 1'b1;
    exp_q.delete();
    repeat (40) tick();
    check("rstmid_no_done", 32'(done_cnt), 32'd0);
    run_sweep("rerun", POS_DEF, NEG_DEF, 1'b0, 1'b0, lat);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout at %0t", $time);
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
